// File: rtl/xcr_tlb_ctrl_if.sv
// Lookup channel bundle between the core's fetch/LSU address paths and the
// MMU. The core side (master) issues requests and VA tags. The MMU side
// (slave) returns registered translations, hit flags and fault pulses.
interface xcr_tlb_ctrl_if;
   logic        i_req;
   logic [7:0]  i_va_h8;
   logic [15:0] i_pa_h16;
   logic        i_hit;
   logic        i_fault;
   logic        d_req;
   logic [7:0]  d_va_h8;
   logic [15:0] d_pa_h16;
   logic        d_hit;
   logic        d_fault;

   modport master (
      output i_req, i_va_h8, d_req, d_va_h8,
      input  i_pa_h16, i_hit, i_fault, d_pa_h16, d_hit, d_fault
   );

   modport slave (
      input  i_req, i_va_h8, d_req, d_va_h8,
      output i_pa_h16, i_hit, i_fault, d_pa_h16, d_hit, d_fault
   );
endinterface

// File: rtl/xcr_tlb_ctrl.sv
// XCR-mapped MMU control block with two fully-associative TLBs (I and D).
// It translates VA[23:16] to PA[31:16] with one registered cycle of latency,
// latches sticky miss faults and runs a shared multi-cycle flush engine.
// Channel index 0 is the I side and index 1 is the D side throughout.
module xcr_tlb_ctrl #(
   parameter int ENTRIES = 4,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cr_din,
   output wire  [7:0]  cr_dout,
   input  logic [3:0]  cr_adr,
   input  logic        cr_we,
   input  logic        cr_cs,
   xcr_tlb_ctrl_if.slave lk,
   output logic        mmu_busy,
   output logic        mmu_enable,
   output logic        supervisor_mode
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   // flush engine
   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [1:0]       fsel_q, fsel_d;
   logic             flush_done_s;

   // control/status registers
   logic             en_q, en_d;
   logic             sup_q, sup_d;
   logic [10:0]      hp_q, hp_d;
   logic [7:0]       stg_va_q, stg_va_d;
   logic [15:0]      stg_pa_q, stg_pa_d;
   logic [1:0]       flt_q, flt_d;
   logic [7:0]       fva_q [2];
   logic [7:0]       fva_d [2];

   // TLB arrays
   logic [IDX_W-1:0]   vic_q   [2];
   logic [IDX_W-1:0]   vic_d   [2];
   logic [ENTRIES-1:0] valid_q [2];
   logic [ENTRIES-1:0] valid_d [2];
   logic [7:0]         tag_q   [2][ENTRIES];
   logic [7:0]         tag_d   [2][ENTRIES];
   logic [15:0]        tpa_q   [2][ENTRIES];
   logic [15:0]        tpa_d   [2][ENTRIES];

   // registered lookup results
   logic [1:0]       hit_q, hit_d;
   logic [1:0]       fault_q, fault_d;
   logic [15:0]      opa_q [2];
   logic [15:0]      opa_d [2];

   // decode and search results
   logic             wr_s, cmd_wr_s, flush_cmd_s, clr_flt_s, busy_s, rd_en_s;
   logic [1:0]       commit_s;
   logic [1:0]       req_s;
   logic [7:0]       va_s [2];
   logic [1:0]       set_flt_s;
   logic [1:0]       match_s, free_s, lk_hit_s;
   logic [IDX_W-1:0] match_idx_s [2];
   logic [IDX_W-1:0] free_idx_s  [2];
   logic [IDX_W-1:0] tgt_s       [2];
   logic [15:0]      lk_pa_s     [2];
   logic [7:0]       rd_data_s;

   assign busy_s      = (state_q == ST_FLUSH);
   assign wr_s        = cr_cs & cr_we;
   assign cmd_wr_s    = wr_s & (cr_adr == 4'h5);
   assign flush_cmd_s = cmd_wr_s & (cr_din[2] | cr_din[3]);
   assign clr_flt_s   = cmd_wr_s & cr_din[4];
   // a flush in the same write, or an ongoing flush, drops any commit
   assign commit_s    = (cmd_wr_s & !busy_s & !(cr_din[2] | cr_din[3])) ?
                        cr_din[1:0] : 2'b00;

   assign req_s   = {lk.d_req, lk.i_req};
   assign va_s[0] = lk.i_va_h8;
   assign va_s[1] = lk.d_va_h8;

   assign lk.i_pa_h16 = opa_q[0];
   assign lk.i_hit    = hit_q[0];
   assign lk.i_fault  = fault_q[0];
   assign lk.d_pa_h16 = opa_q[1];
   assign lk.d_hit    = hit_q[1];
   assign lk.d_fault  = fault_q[1];

   assign mmu_busy        = busy_s;
   assign mmu_enable      = en_q;
   assign supervisor_mode = sup_q;

   // Flush FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fsel_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fsel_q  <= fsel_d;
      end
   end

   // Flush FSM next state: walk every entry once, then release the channels.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fsel_d       = fsel_q;
      flush_done_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_cmd_s) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
               fsel_d  = {cr_din[3], cr_din[2]};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == LAST_IDX) begin
               state_d      = ST_IDLE;
               cnt_d        = '0;
               flush_done_s = 1'b1;
            end else begin
               cnt_d = cnt_q + IDX_W'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Tag search: commit match/free slot and lookup match for each channel.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         match_s[c]     = 1'b0;
         match_idx_s[c] = '0;
         free_s[c]      = 1'b0;
         free_idx_s[c]  = '0;
         lk_hit_s[c]    = 1'b0;
         lk_pa_s[c]     = 16'h0000;
         for (int e = 0; e < ENTRIES; e++) begin
            if (valid_q[c][e] && (tag_q[c][e] == stg_va_q)) begin
               match_s[c]     = 1'b1;
               match_idx_s[c] = IDX_W'(e);
            end else begin
               match_s[c] = match_s[c];
            end
            if (!valid_q[c][e] && !free_s[c]) begin
               free_s[c]     = 1'b1;
               free_idx_s[c] = IDX_W'(e);
            end else begin
               free_s[c] = free_s[c];
            end
            if (valid_q[c][e] && (tag_q[c][e] == va_s[c])) begin
               lk_hit_s[c] = 1'b1;
               lk_pa_s[c]  = tpa_q[c][e];
            end else begin
               lk_hit_s[c] = lk_hit_s[c];
            end
         end
         // in-place update first, then lowest free slot, then the victim
         if (match_s[c]) begin
            tgt_s[c] = match_idx_s[c];
         end else if (free_s[c]) begin
            tgt_s[c] = free_idx_s[c];
         end else begin
            tgt_s[c] = vic_q[c];
         end
      end
   end

   // TLB array update: commits, per-cycle flush clearing, victim pointers.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tpa_d   = tpa_q;
      vic_d   = vic_q;
      for (int c = 0; c < 2; c++) begin
         if (commit_s[c]) begin
            tag_d[c][tgt_s[c]]   = stg_va_q;
            tpa_d[c][tgt_s[c]]   = stg_pa_q;
            valid_d[c][tgt_s[c]] = 1'b1;
            if (!match_s[c] && !free_s[c]) begin
               vic_d[c] = vic_q[c] + IDX_W'(1'b1);
            end else begin
               vic_d[c] = vic_q[c];
            end
         end else begin
            vic_d[c] = vic_q[c];
         end
         if (busy_s && fsel_q[c]) begin
            valid_d[c][cnt_q] = 1'b0;
         end else begin
            valid_d[c] = valid_d[c];
         end
         if (flush_done_s && fsel_q[c]) begin
            vic_d[c] = '0;
         end else begin
            vic_d[c] = vic_d[c];
         end
      end
   end

   // Lookup: pick translation mode and form next registered result.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         hit_d[c]     = 1'b0;
         fault_d[c]   = 1'b0;
         opa_d[c]     = opa_q[c];
         set_flt_s[c] = 1'b0;
         if (req_s[c]) begin
            if (!en_q) begin
               opa_d[c] = {8'h00, va_s[c]};
               hit_d[c] = 1'b1;
            end else if (sup_q) begin
               opa_d[c] = {hp_q, va_s[c][4:0]};
               hit_d[c] = 1'b1;
            end else if (busy_s) begin
               opa_d[c] = 16'h0000;
            end else if (lk_hit_s[c]) begin
               opa_d[c] = lk_pa_s[c];
               hit_d[c] = 1'b1;
            end else begin
               opa_d[c]     = 16'h0000;
               fault_d[c]   = 1'b1;
               set_flt_s[c] = 1'b1;
            end
         end else begin
            opa_d[c] = opa_q[c];
         end
      end
   end

   // Register file writes and sticky fault tracking (a new fault beats clear).
   always_comb begin
      en_d     = en_q;
      sup_d    = sup_q;
      hp_d     = hp_q;
      stg_va_d = stg_va_q;
      stg_pa_d = stg_pa_q;
      flt_d    = flt_q;
      fva_d    = fva_q;
      if (wr_s) begin
         case (cr_adr)
            4'h0: begin
               en_d        = cr_din[7];
               sup_d       = cr_din[6];
               hp_d[10:8]  = cr_din[2:0];
            end
            4'h1: hp_d[7:0]      = cr_din;
            4'h2: stg_va_d       = cr_din;
            4'h3: stg_pa_d[15:8] = cr_din;
            4'h4: stg_pa_d[7:0]  = cr_din;
            default: en_d        = en_q;
         endcase
      end else begin
         en_d = en_q;
      end
      for (int c = 0; c < 2; c++) begin
         if (set_flt_s[c]) begin
            flt_d[c] = 1'b1;
            if (!flt_q[c]) begin
               fva_d[c] = va_s[c];
            end else begin
               fva_d[c] = fva_q[c];
            end
         end else if (clr_flt_s) begin
            flt_d[c] = 1'b0;
         end else begin
            flt_d[c] = flt_q[c];
         end
      end
   end

   // State registers for control, TLB arrays and lookup outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b0;
         sup_q    <= 1'b0;
         hp_q     <= 11'h000;
         stg_va_q <= 8'h00;
         stg_pa_q <= 16'h0000;
         flt_q    <= 2'b00;
         hit_q    <= 2'b00;
         fault_q  <= 2'b00;
         for (int c = 0; c < 2; c++) begin
            fva_q[c]   <= 8'h00;
            vic_q[c]   <= '0;
            valid_q[c] <= '0;
            opa_q[c]   <= 16'h0000;
            for (int e = 0; e < ENTRIES; e++) begin
               tag_q[c][e] <= 8'h00;
               tpa_q[c][e] <= 16'h0000;
            end
         end
      end else begin
         en_q     <= en_d;
         sup_q    <= sup_d;
         hp_q     <= hp_d;
         stg_va_q <= stg_va_d;
         stg_pa_q <= stg_pa_d;
         flt_q    <= flt_d;
         hit_q    <= hit_d;
         fault_q  <= fault_d;
         fva_q    <= fva_d;
         vic_q    <= vic_d;
         valid_q  <= valid_d;
         opa_q    <= opa_d;
         tag_q    <= tag_d;
         tpa_q    <= tpa_d;
      end
   end

   // XCR read mux, combinational from the address.
   always_comb begin
      rd_data_s = 8'h00;
      case (cr_adr)
         4'h0: rd_data_s = {en_q, sup_q, 3'b000, hp_q[10:8]};
         4'h1: rd_data_s = hp_q[7:0];
         4'h2: rd_data_s = stg_va_q;
         4'h3: rd_data_s = stg_pa_q[15:8];
         4'h4: rd_data_s = stg_pa_q[7:0];
         4'h5: rd_data_s = {busy_s, 7'b0000000};
         4'h6: rd_data_s = {flt_q[0], flt_q[1], 6'b000000};
         4'h7: rd_data_s = fva_q[0];
         4'h8: rd_data_s = fva_q[1];
         4'h9: rd_data_s = {4'(vic_q[0]), 4'(vic_q[1])};
         default: rd_data_s = 8'h00;
      endcase
   end

   assign rd_en_s = cr_cs & !cr_we;
   assign cr_dout = rd_en_s ? rd_data_s : 8'hzz;

endmodule

// File: doc/xcr_tlb_ctrl.md
# xcr_tlb_ctrl

Parametrised successor to the single-entry PAE32 MMU control block: an XCR-mapped control register file plus two small fully-associative TLBs (instruction and data), each `ENTRIES` deep. It translates the high 8 bits of a 24-bit VA into a 16-bit PA high part with one cycle of registered latency. It latches sticky miss faults for the exception logic and runs a multi-cycle flush state machine. It sits between the core's fetch/LSU address paths and the physical bus, on the XCR control bus.

## Interface
- `ENTRIES`, 4, entries per TLB; power of two, 2..16.
- `IDX_W`, $clog2(ENTRIES), entry index width; derived, do not override.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cr_din`  in  8  XCR write data.
- `cr_dout`  out  8  XCR read data; 8'hzz unless `cr_cs & !cr_we`.
- `cr_adr`  in  4  XCR register address.
- `cr_we`  in  1  XCR write strobe.
- `cr_cs`  in  1  XCR select.
- `i_req` / `d_req`  in  1  lookup request for the I or D channel.
- `i_va_h8` / `d_va_h8`  in  8  VA[23:16] to translate.
- `i_pa_h16` / `d_pa_h16`  out  16  translated PA[31:16]; registered.
- `i_hit` / `d_hit`  out  1  registered; translation valid.
- `i_fault` / `d_fault`  out  1  registered one-cycle miss pulse.
- `mmu_busy`  out  1  flush in progress.
- `mmu_enable`, `supervisor_mode`  out  1  mode bits.

## Operation
Register map (R/W unless noted):
- 0x0 MMUMOD: {mmu_enable, supervisor_mode, 3'b0, hugepage_ptr[10:8]}.
- 0x1 HPADR: hugepage_ptr[7:0].
- 0x2 STG_VA: staging VA tag.
- 0x3 STG_PA1: staging PA[15:8].
- 0x4 STG_PA0: staging PA[7:0].
- 0x5 CMD: write-only command register. bit0 commit-I, bit1 commit-D, bit2 flush-I, bit3 flush-D, bit4 clear-faults. Reads return {mmu_busy, 7'b0}.
- 0x6 FSTAT (RO): {ifault, dfault, 6'b0}.
- 0x7 IFVA (RO): first faulting I VA tag.
- 0x8 DFVA (RO): first faulting D VA tag.
- 0x9 VICT (RO): {i_victim, d_victim} packed as 4 bits each, zero-extended.
- All other addresses read 8'h00.

Translation mode, evaluated per request:
- `!mmu_enable`: flat mode. PA_h16 = {8'h00, va_h8}; hit = 1.
- `mmu_enable & supervisor_mode`: hugepage mode. PA_h16 = {hugepage_ptr, va_h8[4:0]}; hit = 1.
- `mmu_enable & !supervisor_mode`: TLB mode. A hit on a valid entry with a matching tag returns that entry's PA. A miss gives hit = 0, PA = 16'h0000 and a fault pulse.

Commit:
- If a valid entry in the channel already holds STG_VA, that entry is overwritten in place; no duplicates.
- Otherwise the staging entry goes to the lowest-index invalid entry.
- If the channel is full, it goes to the round-robin victim and the victim increments modulo ENTRIES. The victim pointer advances only on eviction.

Flush FSM, one per design shared by both channels. States: IDLE, FLUSH.
- IDLE→FLUSH on a CMD write with bit2 or bit3 set. The selected channel(s) are recorded and the counter is set to 0.
- In FLUSH, the design clears the valid bit of entry[counter] in the selected channel(s) each cycle.
- FLUSH→IDLE after entry ENTRIES-1 is cleared. Busy time is exactly ENTRIES cycles. The victim pointer(s) of flushed channel(s) reset to 0.

Faults:
- The ifault/dfault status bits are sticky. FxVA captures the first miss only; later misses do not overwrite it while the fault bit is set.
- Clear-faults clears both fault bits.

Boundary and conflict rules:
- Commit and flush in the same CMD write: the flush is taken and the commit is dropped.
- Commit while busy: ignored.
- A TLB-mode lookup while busy returns hit = 0 with no fault pulse and no fault latch.
- A fault in the same cycle as clear-faults: the set wins.
- A CMD write of bit4 together with other bits: each action is performed independently under the rules above.

## Timing
- Lookup result appears the cycle after `x_req`. With no request, outputs hold hit = 0, fault = 0 and the previous PA.
- A lookup in the cycle after a commit write sees the new entry. A register write takes effect at the edge; the lookup samples at the following edge.
- MMUMOD changes affect requests sampled from the next cycle.
- `cr_dout` is combinational from `cr_adr`.
- On reset, all of the following clear to zero and the FSM enters IDLE:
  - outputs;
  - all registers, including hugepage_ptr and the staging registers;
  - valid bits;
  - victim pointers;
  - fault state.
- A reset mid-flush aborts the flush into IDLE, and all valid bits are cleared anyway.

## Test plan
- Reset, then `i_req` with va 8'h5A, mmu disabled → next cycle i_hit = 1, i_pa_h16 = 16'h005A. Read 0x0 returns 8'h00.
- Write MMUMOD 8'hC3 and HPADR 8'h21, then `d_req` va 8'hFF → d_pa_h16 = {11'h321, 5'h1F} = 16'h643F, d_hit = 1.
- TLB mode (MMUMOD 8'h80): commit I entry VA 8'h12→PA 16'hABCD. Lookup 8'h12 → hit, PA 16'hABCD. Lookup 8'h34 → i_fault pulse, FSTAT 8'h80, IFVA 8'h34. A second miss on 8'h56 leaves IFVA at 8'h34. Clear-faults → FSTAT 8'h00.
- With ENTRIES = 4, commit 5 distinct D tags → the 5th replaces entry 0 and VICT low nibble = 1. Recommit an existing tag with a new PA → same slot is updated and VICT is unchanged.
- Fill I, write CMD 8'h05 (commit and flush) → mmu_busy high exactly 4 cycles, commit dropped. A lookup during busy gives hit = 0 with no fault. Afterwards all lookups miss.
- Assert `rst` in the 2nd flush cycle → next cycle mmu_busy = 0, all entries invalid, all outputs zero.
